axi_mem_responder: RTL and testbench

- AXI-style slave memory model/controller: the responder end of the burst read and write channels driven by the core's data and instruction caches.
- Accepts one write burst (AW/W/B) and one read burst (AR/R) at a time. The two channels are independent and may run concurrently.
- Backs the bursts with an internal word-addressed array.
- Used as the simulation and FPGA memory behind the cache AXI master ports.

---
 rtl/axi_mem_responder_if.sv | 55 +++++
 rtl/axi_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_axi_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// Burst read/write channel bundle between a cache AXI master and the memory
// responder. The slave modport is the memory side.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [3:0]            AWID;
  logic [3:0]            AWLEN;
  logic [ADDR_WIDTH-1:0] AWADDR;

  logic                  WVALID;
  logic                  WREADY;
  logic [3:0]            WID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;

  logic                  BVALID;
  logic                  BREADY;
  logic [3:0]            BID;
  logic [1:0]            BRESP;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [3:0]            ARID;
  logic [3:0]            ARLEN;
  logic [ADDR_WIDTH-1:0] ARADDR;

  logic                  RVALID;
  logic                  RREADY;
  logic [3:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RLAST;

  modport slave (
    input  AWVALID, AWID, AWLEN, AWADDR,
    input  WVALID, WID, WDATA, WLAST,
    input  BREADY,
    input  ARVALID, ARID, ARLEN, ARADDR,
    input  RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP,
    output ARREADY, RVALID, RID, RDATA, RLAST
  );

  modport master (
    output AWVALID, AWID, AWLEN, AWADDR,
    output WVALID, WID, WDATA, WLAST,
    output BREADY,
    output ARVALID, ARID, ARLEN, ARADDR,
    output RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP,
    input  ARREADY, RVALID, RID, RDATA, RLAST
  );
endinterface

// File: rtl/axi_mem_responder.sv
// Burst memory responder behind the cache AXI ports: one write burst and one
// read burst in flight at a time, channels independent, backed by a
// word-addressed array that reset leaves untouched.
//
// state  | meaning
// -------+--------------------------------------------------------------
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, storing one word per WVALID beat
// W_RESP | BVALID high with BID/BRESP, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_WAIT | latency countdown before the first read beat
// R_DATA | RVALID high, RDATA read straight from the array
module axi_mem_responder #(
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int READ_LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  axi_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // LEN=0 encodes a full 16-beat burst
  function automatic logic [4:0] beat_count(input logic [3:0] len);
    return (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_t                w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [4:0]              w_cnt_q, w_cnt_d;
  logic [3:0]              bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    mem_we;
  logic                    w_final;

  r_state_t                r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [4:0]              r_cnt_q, r_cnt_d;
  logic [3:0]              rid_q, rid_d;
  logic [3:0]              lat_q, lat_d;

  // Address bits outside the word index and the write-data ID are ignored.
  logic unused_ok;
  assign unused_ok = ^{bus.WID,
                       bus.AWADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], bus.AWADDR[1:0],
                       bus.ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], bus.ARADDR[1:0]};

  assign w_final = (w_cnt_q == 5'd1);

  // Write channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write channel next state: burst ends on the counted last beat or an
  // early WLAST; any disagreement between the two is reported as SLVERR.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.AWVALID) begin
          w_idx_d   = bus.AWADDR[MEM_ADDR_WIDTH+1:2];
          w_cnt_d   = beat_count(bus.AWLEN);
          bid_d     = bus.AWID;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.WVALID) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          w_cnt_d = w_cnt_q - 1'b1;
          if (w_final || bus.WLAST) begin
            bresp_d   = (bus.WLAST != w_final) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[w_idx_q] <= bus.WDATA;
  end

  assign bus.AWREADY = (w_state_q == W_IDLE);
  assign bus.WREADY  = (w_state_q == W_DATA);
  assign bus.BVALID  = (w_state_q == W_RESP);
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;

  // Read channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      lat_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      lat_q     <= lat_d;
    end
  end

  // Read channel next state: latency preload of READ_LATENCY-1 puts the first
  // RVALID exactly READ_LATENCY cycles after the AR handshake edge.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    lat_d     = lat_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.ARVALID) begin
          r_idx_d   = bus.ARADDR[MEM_ADDR_WIDTH+1:2];
          r_cnt_d   = beat_count(bus.ARLEN);
          rid_d     = bus.ARID;
          lat_d     = 4'(READ_LATENCY - 1);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_q == 4'd0) r_state_d = R_DATA;
        else               lat_d     = lat_q - 1'b1;
      end
      R_DATA: begin
        if (bus.RREADY) begin
          r_idx_d = r_idx_q + 1'b1;
          r_cnt_d = r_cnt_q - 1'b1;
          if (r_cnt_q == 5'd1) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign bus.ARREADY = (r_state_q == R_IDLE);
  assign bus.RVALID  = (r_state_q == R_DATA);
  assign bus.RLAST   = (r_state_q == R_DATA) && (r_cnt_q == 5'd1);
  assign bus.RID     = rid_q;
  assign bus.RDATA   = (r_state_q == R_DATA) ? mem_q[r_idx_q] : '0;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a write-burst table, a read-burst
// table checked against a shadow copy of the array, then reset-mid-burst and
// concurrent-channel sequences.
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(12), .READ_LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [25:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    int          wlast_at;   // beat carrying WLAST, -1 for never
    logic [31:0] base;       // beat i carries base+i
    logic [1:0]  exp_resp;
    int          exp_beats;
  } wvec_t;

  typedef struct {
    logic [25:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [3:0]  pat;        // RREADY on cycle c is pat[c%4]
  } rvec_t;

  wvec_t wv[6];
  rvec_t rv[7];
  logic [31:0] shadow [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input wvec_t v);
    int t;
    int beats;
    logic [11:0] idx;
    bus.AWADDR  = v.addr;
    bus.AWLEN   = v.len;
    bus.AWID    = v.id;
    bus.AWVALID = 1'b1;
    t = 0;
    while (!bus.AWREADY && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("aw_ready", bus.AWREADY, 1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.WREADY) break;
      bus.WVALID = 1'b1;
      bus.WDATA  = v.base + i;
      bus.WLAST  = (i == v.wlast_at);
      @(posedge clk); #1;
      beats++;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    check("w_beats", beats, v.exp_beats);
    check("b_valid", bus.BVALID, 1);
    check("b_id", bus.BID, v.id);
    check("b_resp", bus.BRESP, v.exp_resp);
    idx = v.addr[13:2];
    for (int i = 0; i < v.exp_beats; i++) shadow[idx + 12'(i)] = v.base + i;
    @(posedge clk); #1;
    check("b_hold", {bus.BVALID, bus.BRESP}, {1'b1, v.exp_resp});
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check("b_done", bus.BVALID, 0);
    check("aw_ready_after_b", bus.AWREADY, 1);
  endtask

  task automatic do_read(input rvec_t v);
    int t;
    int lat;
    int n;
    int beat;
    int cyc;
    logic [11:0] idx;
    n   = (v.len == 4'd0) ? 16 : int'(v.len);
    idx = v.addr[13:2];
    bus.ARADDR  = v.addr;
    bus.ARLEN   = v.len;
    bus.ARID    = v.id;
    bus.ARVALID = 1'b1;
    t = 0;
    while (!bus.ARREADY && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("ar_ready", bus.ARREADY, 1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    lat = 0;
    while (!bus.RVALID && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("r_latency", lat, 4);
    beat = 0;
    cyc  = 0;
    while (beat < n && cyc < 100) begin
      bus.RREADY = v.pat[cyc % 4];
      check("r_valid", bus.RVALID, 1);
      check("r_data", bus.RDATA, shadow[idx + 12'(beat)]);
      check("r_last", bus.RLAST, (beat == n - 1));
      check("r_id", bus.RID, v.id);
      @(posedge clk); #1;
      if (bus.RREADY) beat++;
      cyc++;
    end
    bus.RREADY = 1'b0;
    check("r_done", bus.RVALID, 0);
    check("ar_ready_after_r", bus.ARREADY, 1);
  endtask

  initial begin
    bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
    bus.WVALID = 0; bus.WID = 0; bus.WDATA = 0; bus.WLAST = 0;
    bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0; bus.ARADDR = 0;
    bus.RREADY = 0;

    wv[0] = '{26'h100,  4'd4, 4'd3, 3,  32'hA0, 2'b00, 4};
    wv[1] = '{26'h200,  4'd2, 4'd5, 1,  32'hB0, 2'b00, 2};
    wv[2] = '{26'h200,  4'd2, 4'd6, 0,  32'hC0, 2'b10, 1};
    wv[3] = '{26'h300,  4'd3, 4'd7, -1, 32'hD0, 2'b10, 3};
    wv[4] = '{26'h3FE0, 4'd0, 4'd9, 15, 32'hE0, 2'b00, 16};
    wv[5] = '{26'h4400, 4'd1, 4'd2, 0,  32'hF0, 2'b00, 1};

    rv[0] = '{26'h100,  4'd4, 4'd8, 4'b1111};
    rv[1] = '{26'h100,  4'd4, 4'd1, 4'b1001};
    rv[2] = '{26'h200,  4'd2, 4'd2, 4'b1111};
    rv[3] = '{26'h300,  4'd3, 4'd3, 4'b0101};
    rv[4] = '{26'h3FE0, 4'd0, 4'd4, 4'b1111};
    rv[5] = '{26'h400,  4'd1, 4'd5, 4'b1111};
    rv[6] = '{26'h0,    4'd8, 4'd6, 4'b0110};

    #1;
    check("rst_awready", bus.AWREADY, 1);
    check("rst_arready", bus.ARREADY, 1);
    check("rst_wready", bus.WREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_ids", {bus.BID, bus.RID}, 0);
    check("rst_bresp", bus.BRESP, 0);
    check("rst_rdata", bus.RDATA, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) do_write(wv[i]);
    for (int i = 0; i < 7; i++) do_read(rv[i]);

    // Reset while the second beat of a 4-beat read is on the bus
    begin
      int t;
      bus.ARADDR = 26'h100; bus.ARLEN = 4'd4; bus.ARID = 4'd12; bus.ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b1;
      t = 0;
      while (!bus.RVALID && t < 40) begin
        @(posedge clk); #1; t++;
      end
      check("mid_first", bus.RDATA, 32'hA0);
      @(posedge clk); #1;
      check("mid_second", bus.RDATA, 32'hA1);
      rst = 1'b1;
      #1;
      check("mid_rst_rvalid", bus.RVALID, 0);
      check("mid_rst_arready", bus.ARREADY, 1);
      check("mid_rst_rlast", bus.RLAST, 0);
      check("mid_rst_rid", bus.RID, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        check("post_rst_quiet", {bus.RVALID, bus.BVALID}, 0);
      end
      bus.RREADY = 1'b0;
      do_read(rv[0]);
    end

    // Write and read bursts running at the same time on disjoint words
    fork
      do_write('{26'h800, 4'd4, 4'd10, 3, 32'h5A0, 2'b00, 4});
      do_read('{26'h100, 4'd4, 4'd11, 4'b1011});
    join
    do_read('{26'h800, 4'd4, 4'd13, 4'b1111});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
